sc_seqshifter: RTL and testbench

Multi-cycle sequential shifter that sits directly upstream of the datapath's general-purpose register. It accepts an operand, a shift mode and a shift amount on a start strobe, then shifts one bit position per clock. When finished, it issues a one-cycle write strobe so the downstream general register captures the result on the following edge.

---
 rtl/sc_seqshifter_pkg.sv | 16 +
 rtl/sc_shiftstep.sv | 19 +
 rtl/sc_seqshifter.sv | 70 +++++++
 tb/tb_sc_seqshifter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sc_seqshifter_pkg.sv
// sc_seqshifter_pkg: shared mode/state encodings and default widths for the sequential shifter
package sc_seqshifter_pkg;
  localparam int DEF_DATAWIDTH_BUS = 32;
  localparam int DEF_SHAMT_WIDTH = 5;
  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/sc_shiftstep.sv
// sc_shiftstep: combinational single-bit shift/rotate step with shifted-out bit
module sc_shiftstep
  import sc_seqshifter_pkg::*;
#(
  parameter int WIDTH = DEF_DATAWIDTH_BUS
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out
);
  always_comb begin
    bit_out  = (mode == MODE_SLL) ? data[WIDTH-1] : data[0];
    data_out = (mode == MODE_SLL) ? {data[WIDTH-2:0], 1'b0} :
               (mode == MODE_SRL) ? {1'b0, data[WIDTH-1:1]} :
               (mode == MODE_SRA) ? {data[WIDTH-1], data[WIDTH-1:1]} :
                                    {data[0], data[WIDTH-1:1]};
  end
endmodule

// File: rtl/sc_seqshifter.sv
// sc_seqshifter: multi-cycle shifter, one bit per clock, with a one-cycle write strobe on completion
module sc_seqshifter
  import sc_seqshifter_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int SHAMT_WIDTH   = DEF_SHAMT_WIDTH
) (
  input  logic                     SC_SEQSHIFTER_CLOCK_50,
  input  logic                     SC_SEQSHIFTER_Reset_InHigh,
  input  logic                     SC_SEQSHIFTER_Start_InHigh,
  input  logic [1:0]               SC_SEQSHIFTER_Mode_In,
  input  logic [SHAMT_WIDTH-1:0]   SC_SEQSHIFTER_Shamt_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_SEQSHIFTER_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0] SC_SEQSHIFTER_DataBUS_Out,
  output logic                     SC_SEQSHIFTER_Write_OutHigh,
  output logic                     SC_SEQSHIFTER_Busy_OutHigh,
  output logic                     SC_SEQSHIFTER_Carry_Out
);
  state_t                   state;
  mode_t                    mode_q;
  logic [SHAMT_WIDTH-1:0]   cnt;
  logic [DATAWIDTH_BUS-1:0] step_data;
  logic                     step_bit;

  sc_shiftstep #(.WIDTH(DATAWIDTH_BUS)) u_step (
    .mode     (mode_q),
    .data     (SC_SEQSHIFTER_DataBUS_Out),
    .data_out (step_data),
    .bit_out  (step_bit)
  );

  // Write and Busy are registered alongside the state so they track it exactly
  always_ff @(posedge SC_SEQSHIFTER_CLOCK_50 or posedge SC_SEQSHIFTER_Reset_InHigh) begin
    if (SC_SEQSHIFTER_Reset_InHigh) begin
      state                       <= ST_IDLE;
      mode_q                      <= MODE_SLL;
      cnt                         <= '0;
      SC_SEQSHIFTER_DataBUS_Out   <= '0;
      SC_SEQSHIFTER_Write_OutHigh <= 1'b0;
      SC_SEQSHIFTER_Busy_OutHigh  <= 1'b0;
      SC_SEQSHIFTER_Carry_Out     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (SC_SEQSHIFTER_Start_InHigh) begin
          SC_SEQSHIFTER_DataBUS_Out   <= SC_SEQSHIFTER_DataBUS_In;
          mode_q                      <= mode_t'(SC_SEQSHIFTER_Mode_In);
          cnt                         <= SC_SEQSHIFTER_Shamt_In;
          SC_SEQSHIFTER_Carry_Out     <= 1'b0;
          SC_SEQSHIFTER_Busy_OutHigh  <= 1'b1;
          SC_SEQSHIFTER_Write_OutHigh <= (SC_SEQSHIFTER_Shamt_In == '0);
          state                       <= (SC_SEQSHIFTER_Shamt_In == '0) ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          SC_SEQSHIFTER_DataBUS_Out <= step_data;
          SC_SEQSHIFTER_Carry_Out   <= step_bit;
          cnt                       <= cnt - 1'b1;
          if (cnt == SHAMT_WIDTH'(1)) begin
            state                       <= ST_DONE;
            SC_SEQSHIFTER_Write_OutHigh <= 1'b1;
          end
        end
        default: begin
          state                       <= ST_IDLE;
          SC_SEQSHIFTER_Write_OutHigh <= 1'b0;
          SC_SEQSHIFTER_Busy_OutHigh  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sc_seqshifter.sv
// tb_sc_seqshifter: directed vectors plus an arithmetic reference model checked every cycle
module tb_sc_seqshifter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        write, busy, carry;
  int          checks = 0;
  int          errors = 0;

  sc_seqshifter dut (
    .SC_SEQSHIFTER_CLOCK_50      (clk),
    .SC_SEQSHIFTER_Reset_InHigh  (rst),
    .SC_SEQSHIFTER_Start_InHigh  (start),
    .SC_SEQSHIFTER_Mode_In       (mode),
    .SC_SEQSHIFTER_Shamt_In      (shamt),
    .SC_SEQSHIFTER_DataBUS_In    (din),
    .SC_SEQSHIFTER_DataBUS_Out   (dout),
    .SC_SEQSHIFTER_Write_OutHigh (write),
    .SC_SEQSHIFTER_Busy_OutHigh  (busy),
    .SC_SEQSHIFTER_Carry_Out     (carry)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] shf(input logic [31:0] op, input logic [1:0] md, input int k);
    case (md)
      2'd0: return op << k;
      2'd1: return op >> k;
      2'd2: return 32'($signed(op) >>> k);
      default: return (k == 0) ? op : ((op >> k) | (op << (32 - k)));
    endcase
  endfunction

  // bit removed by the k-th single step: original bit 32-k for left shifts, k-1 otherwise
  function automatic logic cry(input logic [31:0] op, input logic [1:0] md, input int k);
    if (k == 0) return 1'b0;
    return (md == 2'd0) ? op[32 - k] : op[k - 1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic        m_active, m_lastc;
  logic [31:0] m_op, m_last;
  logic [1:0]  m_mode;
  int          m_n, m_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_last   <= 32'h0;
      m_lastc  <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_op     <= din;
        m_mode   <= mode;
        m_n      <= int'(shamt);
        m_t      <= 0;
        m_active <= 1'b1;
      end
    end else if (m_t == m_n) begin
      m_active <= 1'b0;
      m_last   <= shf(m_op, m_mode, m_n);
      m_lastc  <= cry(m_op, m_mode, m_n);
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_data",  dout,  m_active ? shf(m_op, m_mode, m_t) : m_last);
    chk("model_carry", 32'(carry), 32'(m_active ? cry(m_op, m_mode, m_t) : m_lastc));
    chk("model_busy",  32'(busy),  32'(m_active));
    chk("model_write", 32'(write), 32'(m_active && m_t == m_n));
  end

  task automatic run(input logic [1:0] md, input logic [4:0] sh, input logic [31:0] d,
                     input logic [31:0] ed, input logic ec, input int re_k);
    int wc = 0, wk = -1, bc = 0, fin = 0;
    @(negedge clk);
    start = 1'b1; mode = md; shamt = sh; din = d;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      start = (k == re_k);
      mode  = 2'($urandom);
      shamt = 5'($urandom);
      din   = $urandom;
      if (write) begin wc++; wk = k; end
      if (busy) bc++;
      else begin fin = 1; break; end
    end
    chk("finished", 32'(fin), 32'd1);
    chk("write_latency", 32'(wk), 32'(int'(sh) + 1));
    chk("write_count", 32'(wc), 32'd1);
    chk("busy_cycles", 32'(bc), 32'(int'(sh) + 1));
    chk("result", dout, ed);
    chk("carry", 32'(carry), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    @(negedge clk);
    chk("rst_data", dout, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data", dout, 32'h0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    run(2'd0, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 0);
    run(2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run(2'd3, 5'd1,  32'h0000_0003, 32'h8000_0001, 1'b1, 0);
    run(2'd1, 5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1, 0);
    run(2'd0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    run(2'd0, 5'd1,  32'h8000_0001, 32'h0000_0002, 1'b1, 0);
    run(2'd2, 5'd4,  32'h0000_00F8, 32'h0000_000F, 1'b1, 0);
    run(2'd3, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0, 0);
    run(2'd0, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 2);
    run(2'd1, 5'd3,  32'h0000_00F0, 32'h0000_001E, 1'b0, 4);

    repeat (3) @(negedge clk);
    chk("idle_hold", dout, 32'h0000_001E);
    #2 rst = 1'b1;
    #1 chk("idle_rst_data", dout, 32'h0);
    chk("idle_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rel_data", dout, 32'h0);
    chk("idle_rel_busy", 32'(busy), 32'd0);

    start = 1'b1; mode = 2'd0; shamt = 5'd8; din = 32'h0000_00FF;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_shift_data", dout, 32'h0000_03FC);
    chk("mid_shift_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("abort_data", dout, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_write", 32'(write), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wc = 0;
    repeat (12) begin
      @(negedge clk);
      if (write || busy) wc++;
    end
    chk("abort_no_write", 32'(wc), 32'd0);

    run(2'd1, 5'd2, 32'h0000_000D, 32'h0000_0003, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
